// File: rtl/uart_if.sv
// Byte-side client bus of the UART: transmit request/data and receive data/strobe.
interface uart_if;
    logic [7:0] data_in;
    logic       data_send;
    logic       data_sent;
    logic [7:0] data_out;
    logic       data_received;

    // Bus client that supplies bytes to send and consumes received bytes
    modport master (
        output data_in,
        output data_send,
        input  data_sent,
        input  data_out,
        input  data_received
    );

    // UART side of the bus
    modport slave (
        input  data_in,
        input  data_send,
        output data_sent,
        output data_out,
        output data_received
    );
endinterface

// File: rtl/uart.sv
// Full-duplex 8N1 UART. The receiver and transmitter share one system clock and
// run independently; bit timing comes from a fixed clocks-per-bit divide count.
// Frame: start bit (0), 8 data bits LSB first, stop bit (1), no parity.
module uart #(
    parameter int CLK_PER_BIT = 48
) (
    input  logic clk,
    input  logic rst,        // asynchronous, active-low
    input  logic uart_rxd,   // idle high, asynchronous to clk
    output logic uart_txd,   // idle high
    uart_if.slave bus
);

    localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'((CLK_PER_BIT / 2) - 1);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // Receive-side state
    logic      rxd_meta_r;
    logic      rxd_sync_r;
    logic      rxd_prev_r;
    logic      rx_fall_s;
    rx_state_t rx_state_r;
    logic [CW-1:0] rx_cnt_r;
    logic [2:0]    rx_bit_r;
    logic [7:0]    rx_shift_r;
    logic [7:0]    rx_data_r;
    logic          rx_valid_r;

    // Transmit-side state
    tx_state_t tx_state_r;
    logic [CW-1:0] tx_cnt_r;
    logic [2:0]    tx_bit_r;
    logic [7:0]    tx_shift_r;
    logic          tx_txd_r;
    logic          tx_sent_r;

    assign uart_txd          = tx_txd_r;
    assign bus.data_sent     = tx_sent_r;
    assign bus.data_out      = rx_data_r;
    assign bus.data_received = rx_valid_r;

    // Falling edge of the synchronized line marks a candidate start bit
    assign rx_fall_s = rxd_prev_r & ~rxd_sync_r;

    // Two-flop synchronizer for the asynchronous RX pin plus a delayed copy for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_meta_r <= 1'b1;
            rxd_sync_r <= 1'b1;
            rxd_prev_r <= 1'b1;
        end else begin
            rxd_meta_r <= uart_rxd;
            rxd_sync_r <= rxd_meta_r;
            rxd_prev_r <= rxd_sync_r;
        end
    end

    // Receiver FSM: validate start at mid-bit, sample data at bit centres, check stop bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_r <= RX_IDLE;
            rx_cnt_r   <= CNT_ZERO;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'h00;
            rx_data_r  <= 8'h00;
            rx_valid_r <= 1'b0;
        end else begin
            rx_valid_r <= 1'b0;
            case (rx_state_r)
                RX_IDLE: begin
                    rx_cnt_r <= CNT_ZERO;
                    rx_bit_r <= 3'd0;
                    if (rx_fall_s) begin
                        rx_state_r <= RX_START;
                    end else begin
                        rx_state_r <= RX_IDLE;
                    end
                end
                RX_START: begin
                    if (rx_cnt_r == CNT_HALF) begin
                        rx_cnt_r <= CNT_ZERO;
                        // A line already back high at mid-start was only a glitch
                        if (rxd_sync_r == 1'b0) begin
                            rx_state_r <= RX_DATA;
                        end else begin
                            rx_state_r <= RX_IDLE;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_r == CNT_LAST) begin
                        rx_cnt_r   <= CNT_ZERO;
                        rx_shift_r <= {rxd_sync_r, rx_shift_r[7:1]};
                        if (rx_bit_r == 3'd7) begin
                            rx_state_r <= RX_STOP;
                        end else begin
                            rx_bit_r <= rx_bit_r + 3'd1;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CNT_ONE;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_r == CNT_LAST) begin
                        rx_cnt_r   <= CNT_ZERO;
                        rx_state_r <= RX_IDLE;
                        // A low stop bit is a framing error: the byte is dropped
                        if (rxd_sync_r == 1'b1) begin
                            rx_data_r  <= rx_shift_r;
                            rx_valid_r <= 1'b1;
                        end else begin
                            rx_data_r <= rx_data_r;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    rx_state_r <= RX_IDLE;
                    rx_cnt_r   <= CNT_ZERO;
                    rx_bit_r   <= 3'd0;
                end
            endcase
        end
    end

    // Transmitter FSM: each state holds the registered line level for one full bit period
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_r <= TX_IDLE;
            tx_cnt_r   <= CNT_ZERO;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'h00;
            tx_txd_r   <= 1'b1;
            tx_sent_r  <= 1'b0;
        end else begin
            tx_sent_r <= 1'b0;
            case (tx_state_r)
                TX_IDLE: begin
                    tx_cnt_r <= CNT_ZERO;
                    tx_bit_r <= 3'd0;
                    if (bus.data_send) begin
                        tx_shift_r <= bus.data_in;
                        tx_txd_r   <= 1'b0;
                        tx_state_r <= TX_START;
                    end else begin
                        tx_txd_r   <= 1'b1;
                        tx_state_r <= TX_IDLE;
                    end
                end
                TX_START: begin
                    if (tx_cnt_r == CNT_LAST) begin
                        tx_cnt_r   <= CNT_ZERO;
                        tx_txd_r   <= tx_shift_r[0];
                        tx_state_r <= TX_DATA;
                    end else begin
                        tx_cnt_r <= tx_cnt_r + CNT_ONE;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_r == CNT_LAST) begin
                        tx_cnt_r <= CNT_ZERO;
                        if (tx_bit_r == 3'd7) begin
                            tx_txd_r   <= 1'b1;
                            tx_state_r <= TX_STOP;
                        end else begin
                            tx_bit_r   <= tx_bit_r + 3'd1;
                            tx_shift_r <= {1'b0, tx_shift_r[7:1]};
                            tx_txd_r   <= tx_shift_r[1];
                        end
                    end else begin
                        tx_cnt_r <= tx_cnt_r + CNT_ONE;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt_r == CNT_LAST) begin
                        tx_cnt_r   <= CNT_ZERO;
                        tx_sent_r  <= 1'b1;
                        tx_state_r <= TX_IDLE;
                    end else begin
                        tx_cnt_r <= tx_cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    tx_state_r <= TX_IDLE;
                    tx_cnt_r   <= CNT_ZERO;
                    tx_txd_r   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart.sv
// Directed testbench for the 8N1 UART: reset state, RX frames, glitch and
// framing-error rejection, TX waveform and back-to-back timing, loopback,
// and reset in the middle of a frame.
module tb_uart;

    localparam int CPB = 48;

    logic clk;
    logic rst;
    logic rxd_tb;
    logic loopback;
    logic rxd_line;
    logic txd;

    int n_vec;
    int n_err;
    int rx_pulses;
    int tx_pulses;
    logic bad_in_reset;

    uart_if u_bus ();

    assign rxd_line = loopback ? txd : rxd_tb;

    uart #(.CLK_PER_BIT(CPB)) dut (
        .clk      (clk),
        .rst      (rst),
        .uart_rxd (rxd_line),
        .uart_txd (txd),
        .bus      (u_bus)
    );

    // 100 MHz system clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse counters and reset-state watcher, sampled on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            if (u_bus.data_received) rx_pulses <= rx_pulses + 1;
            if (u_bus.data_sent)     tx_pulses <= tx_pulses + 1;
        end else begin
            if (txd !== 1'b1 || u_bus.data_received !== 1'b0 ||
                u_bus.data_sent !== 1'b0 || u_bus.data_out !== 8'h00)
                bad_in_reset <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one serial frame on the RX pin, 48 clocks per bit
    task automatic send_rx(input logic [7:0] b, input logic stop_bit);
        rxd_tb = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd_tb = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd_tb = stop_bit;
        repeat (CPB) @(negedge clk);
        rxd_tb = 1'b1;
    endtask

    task automatic wait_rx(input int maxc, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (u_bus.data_received) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_txd_low(input int maxc, output logic ok, output int waited);
        ok = 1'b0;
        waited = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            waited++;
            if (txd == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Sample the ten bit centres of a TX frame whose start was just seen
    task automatic capture_tx(output logic [9:0] bits);
        repeat (CPB / 2) @(negedge clk);
        bits[0] = txd;
        for (int i = 1; i < 10; i++) begin
            repeat (CPB) @(negedge clk);
            bits[i] = txd;
        end
    endtask

    initial begin
        logic       ok;
        int         waited;
        int         rx_base;
        int         tx_base;
        logic [9:0] bits;
        logic [7:0] lb_bytes [3];

        n_vec = 0;
        n_err = 0;
        rx_pulses = 0;
        tx_pulses = 0;
        bad_in_reset = 1'b0;
        loopback = 1'b0;
        rxd_tb = 1'b1;
        u_bus.data_in = 8'h00;
        u_bus.data_send = 1'b0;

        // Reset held with activity on the inputs
        rst = 1'b0;
        repeat (5) @(negedge clk);
        u_bus.data_in = 8'h5A;
        u_bus.data_send = 1'b1;
        rxd_tb = 1'b0;
        repeat (15) @(negedge clk);
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_rcvd", 32'(u_bus.data_received), 32'd0);
        chk("rst_sent", 32'(u_bus.data_sent), 32'd0);
        chk("rst_dout", 32'(u_bus.data_out), 32'h00);
        chk("rst_hold", 32'(bad_in_reset), 32'd0);
        u_bus.data_send = 1'b0;
        rxd_tb = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);

        // Valid RX frame 0xAC
        send_rx(8'hAC, 1'b1);
        repeat (20) @(negedge clk);
        chk("rx_ac_cnt", 32'(rx_pulses), 32'd1);
        chk("rx_ac_data", 32'(u_bus.data_out), 32'hAC);
        chk("rx_ac_notx", 32'(tx_pulses), 32'd0);
        chk("rx_ac_txd", 32'(txd), 32'd1);

        // Short low glitch must be rejected
        rxd_tb = 1'b0;
        repeat (10) @(negedge clk);
        rxd_tb = 1'b1;
        repeat (100) @(negedge clk);
        chk("glitch_cnt", 32'(rx_pulses), 32'd1);
        chk("glitch_data", 32'(u_bus.data_out), 32'hAC);

        // Framing error then a good frame
        send_rx(8'h33, 1'b0);
        repeat (20) @(negedge clk);
        chk("ferr_cnt", 32'(rx_pulses), 32'd1);
        chk("ferr_data", 32'(u_bus.data_out), 32'hAC);
        send_rx(8'h55, 1'b1);
        repeat (20) @(negedge clk);
        chk("rx_55_cnt", 32'(rx_pulses), 32'd2);
        chk("rx_55_data", 32'(u_bus.data_out), 32'h55);

        // TX 0xA0 held request: frame, back-to-back spacing, mid-frame data change
        u_bus.data_in = 8'hA0;
        u_bus.data_send = 1'b1;
        wait_txd_low(10, ok, waited);
        chk("tx1_start", 32'(ok), 32'd1);
        u_bus.data_in = 8'h5A;
        capture_tx(bits);
        chk("tx1_bits", 32'(bits), 32'h340);
        wait_txd_low(100, ok, waited);
        chk("tx2_start", 32'(ok), 32'd1);
        chk("tx_period", 32'(CPB / 2 + 9 * CPB + waited), 32'd481);
        u_bus.data_send = 1'b0;
        capture_tx(bits);
        chk("tx2_bits", 32'(bits), 32'h2B4);
        wait_txd_low(100, ok, waited);
        chk("tx_stopped", 32'(ok), 32'd0);
        chk("tx_sent_cnt", 32'(tx_pulses), 32'd2);

        // Loopback
        loopback = 1'b1;
        lb_bytes[0] = 8'h00;
        lb_bytes[1] = 8'hFF;
        lb_bytes[2] = 8'h3C;
        repeat (5) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            u_bus.data_in = lb_bytes[k];
            u_bus.data_send = 1'b1;
            @(negedge clk);
            u_bus.data_send = 1'b0;
            wait_rx(700, ok);
            chk("lb_done", 32'(ok), 32'd1);
            chk("lb_data", 32'(u_bus.data_out), 32'(lb_bytes[k]));
            repeat (60) @(negedge clk);
        end
        chk("lb_rx_cnt", 32'(rx_pulses), 32'd5);
        chk("lb_tx_cnt", 32'(tx_pulses), 32'd5);

        // Reset in the middle of a TX frame
        loopback = 1'b0;
        u_bus.data_in = 8'hC3;
        u_bus.data_send = 1'b1;
        @(negedge clk);
        u_bus.data_send = 1'b0;
        repeat (100) @(negedge clk);
        rx_base = rx_pulses;
        tx_base = tx_pulses;
        rst = 1'b0;
        #1;
        chk("mid_rst_txd", 32'(txd), 32'd1);
        chk("mid_rst_dout", 32'(u_bus.data_out), 32'h00);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (600) @(negedge clk);
        chk("post_rst_tx", 32'(tx_pulses), 32'(tx_base));
        chk("post_rst_rx", 32'(rx_pulses), 32'(rx_base));
        chk("post_rst_txd", 32'(txd), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
